// File: rtl/fastdac_pattern_gen.sv
// fastdac_pattern_gen: multi-channel DAC pattern source (sequence RAM, RNG, constant) with offset, saturation and sample shift.
module fastdac_pattern_gen #(
  parameter int NCH = 2,
  parameter int SPC = 8,
  parameter int SW  = 16,
  parameter int AW  = 8,
  localparam int CW  = NCH > 1 ? $clog2(NCH) : 1,
  localparam int SHW = $clog2(SPC)
) (
  input  logic                  tx_core_clk,
  input  logic                  tx_core_reset,
  input  logic                  en_i,
  input  logic                  trig_i,
  input  logic                  seq_wen_i,
  input  logic [CW-1:0]         seq_ch_i,
  input  logic [AW-1:0]         seq_addr_i,
  input  logic [SPC*SW-1:0]     seq_din_i,
  input  logic [AW-1:0]         max_addr_i,
  input  logic [2*NCH-1:0]      mode_i,
  input  logic [NCH*SPC-1:0]    rng_i,
  input  logic                  rng_valid_i,
  input  logic [NCH*2*SW-1:0]   amp_i,
  input  logic [NCH*SW-1:0]     offset_i,
  input  logic [NCH*SHW-1:0]    shift_i,
  input  logic                  tx_tready_i,
  output logic                  tx_tvalid_o,
  output logic [NCH*SPC*SW-1:0] tx_tdata_o,
  output logic                  rng_underrun_o
);
  localparam logic [SW-1:0] SAT_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic [SW-1:0] SAT_MIN = {1'b1, {(SW-1){1'b0}}};
  logic [AW-1:0] ptr_q;
  logic s1_v_q, s2_v_q, s3_v_q, und_q, rng_mode, adv;
  assign adv = en_i & (tx_tready_i | ~s3_v_q);
  assign tx_tvalid_o = s3_v_q;
  assign rng_underrun_o = und_q;
  always_comb begin
    rng_mode = 1'b0;
    for (int c = 0; c < NCH; c++) rng_mode = rng_mode | (mode_i[2*c +: 2] == 2'b10);
  end
  always_ff @(posedge tx_core_clk) begin
    if (tx_core_reset || trig_i) begin
      ptr_q  <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      if (adv) begin
        ptr_q  <= ptr_q >= max_addr_i ? '0 : ptr_q + AW'(1);
        s1_v_q <= 1'b1;
        s2_v_q <= s1_v_q;
        s3_v_q <= s2_v_q;
      end else if (!en_i && tx_tready_i) s3_v_q <= 1'b0;
      // an RNG word is consumed whenever stage 2 loads a real word
      if (adv && s1_v_q && rng_mode && !rng_valid_i) und_q <= 1'b1;
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SPC*SW-1:0] mem_q [2**AW];
    logic [SPC*SW-1:0] s1_q, s2_d, s2_q, sat_d, prev_q, out_d, out_q;
    logic [1:0] md;
    logic [SW-1:0] amp0, amp1, off;
    logic [SHW-1:0] sh;
    assign md   = mode_i[2*c +: 2];
    assign amp0 = amp_i[c*2*SW +: SW];
    assign amp1 = amp_i[c*2*SW+SW +: SW];
    assign off  = offset_i[c*SW +: SW];
    assign sh   = shift_i[c*SHW +: SHW];
    assign tx_tdata_o[c*SPC*SW +: SPC*SW] = out_q;
    always_comb begin
      s2_d = '0;
      for (int k = 0; k < SPC; k++)
        s2_d[k*SW +: SW] = md == 2'b01 ? s1_q[k*SW +: SW] :
                           md == 2'b10 ? (rng_i[c*SPC+k] ? amp1 : amp0) :
                           md == 2'b11 ? amp0 : '0;
    end
    always_comb begin
      logic [SW:0] sum;
      int shv;
      sum   = '0;
      sat_d = '0;
      out_d = '0;
      shv   = int'(sh);
      for (int k = 0; k < SPC; k++) begin
        sum = {s2_q[k*SW+SW-1], s2_q[k*SW +: SW]} + {off[SW-1], off};
        sat_d[k*SW +: SW] = (sum[SW] ^ sum[SW-1]) ? (sum[SW] ? SAT_MIN : SAT_MAX) : sum[SW-1:0];
      end
      // low samples of a shifted word come from the top of the previous word
      for (int k = 0; k < SPC; k++)
        out_d[k*SW +: SW] = k >= shv ? sat_d[(k-shv)*SW +: SW] : prev_q[(SPC+k-shv)*SW +: SW];
    end
    always_ff @(posedge tx_core_clk) begin
      if (seq_wen_i && seq_ch_i == CW'(c)) mem_q[seq_addr_i] <= seq_din_i;
      if (adv) s1_q <= mem_q[ptr_q];
      if (adv) s2_q <= s2_d;
      if (tx_core_reset || trig_i) prev_q <= '0;
      else if (adv && s2_v_q) prev_q <= sat_d;
      if (tx_core_reset) out_q <= '0;
      else if (adv) out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_fastdac_pattern_gen.sv
// tb_fastdac_pattern_gen: scoreboard bench, directed pattern vectors for fastdac_pattern_gen.
module tb_fastdac_pattern_gen;
  localparam int NCH = 2, SPC = 8, SW = 16, AW = 8, WW = NCH*SPC*SW, CWD = SPC*SW;
  logic clk = 0, rst = 1, en = 0, trig = 0, wen = 0, ch = 0, rv = 1, tready = 1;
  logic [AW-1:0] addr = '0, max_a = '0;
  logic [CWD-1:0] din = '0;
  logic [2*NCH-1:0] mode = '0;
  logic [NCH*SPC-1:0] rng = '0;
  logic [NCH*2*SW-1:0] amp = '0;
  logic [NCH*SW-1:0] off = '0;
  logic [NCH*3-1:0] sh = '0;
  logic tvalid, und;
  logic [WW-1:0] tdata, hold;
  int checks = 0, passed = 0;
  logic [WW-1:0] exp_q[$];
  always #5 clk = ~clk;
  fastdac_pattern_gen #(.NCH(NCH), .SPC(SPC), .SW(SW), .AW(AW)) dut (
    .tx_core_clk(clk), .tx_core_reset(rst), .en_i(en), .trig_i(trig),
    .seq_wen_i(wen), .seq_ch_i(ch), .seq_addr_i(addr), .seq_din_i(din),
    .max_addr_i(max_a), .mode_i(mode), .rng_i(rng), .rng_valid_i(rv),
    .amp_i(amp), .offset_i(off), .shift_i(sh), .tx_tready_i(tready),
    .tx_tvalid_o(tvalid), .tx_tdata_o(tdata), .rng_underrun_o(und)
  );
  task automatic check(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk)
    if (!rst && tvalid && tready && exp_q.size() > 0) check("word", tdata, exp_q.pop_front());
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d words left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic stop();
    en = 0;
    tready = 1;
    tick();
    tick();
  endtask
  task automatic restart();
    trig = 1;
    en = 1;
    tick();
    trig = 0;
  endtask
  function automatic logic [CWD-1:0] ramp_word(int n, int s);
    logic [CWD-1:0] r = '0;
    for (int k = 0; k < SPC; k++) begin
      int idx = n*SPC + k - s;
      r[k*SW +: SW] = idx < 0 ? '0 : SW'(idx % 32);
    end
    return r;
  endfunction
  function automatic logic [CWD-1:0] fill(logic [SW-1:0] v, int zeros);
    logic [CWD-1:0] r = '0;
    for (int k = 0; k < SPC; k++) r[k*SW +: SW] = k < zeros ? '0 : v;
    return r;
  endfunction
  function automatic logic [CWD-1:0] rng_word(logic [7:0] bits);
    logic [CWD-1:0] r = '0;
    for (int k = 0; k < SPC; k++) r[k*SW +: SW] = bits[k] ? 16'hE000 : 16'h4000;
    return r;
  endfunction
  initial begin
    tick();
    tick();
    check("rst_tvalid", WW'(tvalid), '0);
    check("rst_tdata", tdata, '0);
    check("rst_underrun", WW'(und), '0);
    rst = 0;
    for (int w = 0; w < 4; w++) begin
      wen = 1; ch = 0; addr = AW'(w); din = ramp_word(w, 0);
      tick();
    end
    wen = 0;
    // sequence ramp on ch0, ch1 zero, rng_valid low must not matter
    mode = 4'b0001; max_a = 3; rv = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back({fill(16'h0, 0), ramp_word(i % 4, 0)});
    restart();
    tick();
    tick();
    check("latency_2", WW'(tvalid), '0);
    tick();
    check("latency_3", WW'(tvalid), WW'(1));
    drain();
    check("no_underrun_seq", WW'(und), '0);
    stop();
    // RNG mode
    mode = 4'b1010; rv = 1; rng = 16'hA5A5;
    amp = {16'hE000, 16'h4000, 16'hE000, 16'h4000};
    for (int i = 0; i < 4; i++) exp_q.push_back({rng_word(8'hA5), rng_word(8'hA5)});
    restart();
    drain();
    check("underrun_clean", WW'(und), '0);
    rv = 0;
    tick();
    rv = 1;
    tick();
    check("underrun_set", WW'(und), WW'(1));
    stop();
    check("underrun_sticky", WW'(und), WW'(1));
    trig = 1;
    tick();
    trig = 0;
    check("underrun_trig_clr", WW'(und), '0);
    // constant mode saturation both directions
    mode = 4'b1111;
    amp = {16'h0, 16'h9000, 16'h0, 16'h7000};
    off = {16'h9000, 16'h2000};
    for (int i = 0; i < 3; i++) exp_q.push_back({fill(16'h8000, 0), fill(16'h7FFF, 0)});
    restart();
    drain();
    stop();
    // shifted ramp and shifted constant
    mode = 4'b1101; off = '0;
    amp = {16'h0, 16'h0123, 32'h0};
    sh = {3'd5, 3'd3};
    for (int i = 0; i < 6; i++) exp_q.push_back({fill(16'h0123, i == 0 ? 5 : 0), ramp_word(i, 3)});
    restart();
    drain();
    stop();
    // backpressure and mid-stream trig
    sh = '0; mode = 4'b0001; amp = '0;
    for (int i = 0; i < 8; i++) exp_q.push_back({fill(16'h0, 0), ramp_word(i % 4, 0)});
    restart();
    tick(); tick(); tick(); tick();
    tready = 0;
    hold = tdata;
    tick();
    check("hold_1", tdata, hold);
    tick();
    check("hold_2", tdata, hold);
    tready = 1;
    drain();
    tready = 0;
    trig = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back({fill(16'h0, 0), ramp_word(i, 0)});
    tick();
    trig = 0;
    tready = 1;
    check("trig_drop", WW'(tvalid), '0);
    drain();
    stop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
